// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-command and status signals around mem_port_arbiter.
// The arb modport is the arbiter's view; tb is the environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              r0_req;
    logic              r0_mode;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    logic              r1_req;
    logic              r1_mode;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    logic              mem_valid;
    logic              mem_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport arb (
        input  r0_req, r0_mode, r0_addr, r0_wdata,
        input  r1_req, r1_mode, r1_addr, r1_wdata,
        input  mem_ready, mem_rdata,
        output r0_ack, r0_rdata, r0_err,
        output r1_ack, r1_rdata, r1_err,
        output mem_valid, mem_mode, mem_addr, mem_wdata,
        output busy, owner
    );

    modport tb (
        output r0_req, r0_mode, r0_addr, r0_wdata,
        output r1_req, r1_mode, r1_addr, r1_wdata,
        output mem_ready, mem_rdata,
        input  r0_ack, r0_rdata, r0_err,
        input  r1_ack, r1_rdata, r1_err,
        input  mem_valid, mem_mode, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter serialising read/write requests onto one
// valid/ready memory command interface, with a per-command timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.arb      bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              grant;
    logic              ack0, ack1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (bus.r0_req || bus.r1_req) begin
                    // On a tie the port that did not win last time goes next.
                    grant   = (bus.r0_req && bus.r1_req) ? ~last_q : bus.r1_req;
                    owner_d = grant;
                    last_d  = grant;
                    cnt_d   = '0;
                    mode_d  = grant ? bus.r1_mode  : bus.r0_mode;
                    addr_d  = grant ? bus.r1_addr  : bus.r0_addr;
                    wdata_d = grant ? bus.r1_wdata : bus.r0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A ready arriving in the expiry cycle still counts as success.
                if (bus.mem_ready) begin
                    rdata_d = mode_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack0 = (state_q == S_RESP) && !owner_q;
    assign ack1 = (state_q == S_RESP) &&  owner_q;

    assign bus.r0_ack    = ack0;
    assign bus.r1_ack    = ack1;
    assign bus.r0_rdata  = ack0 ? rdata_q : '0;
    assign bus.r1_rdata  = ack1 ? rdata_q : '0;
    assign bus.r0_err    = ack0 && err_q;
    assign bus.r1_err    = ack1 && err_q;

    assign bus.mem_valid = (state_q == S_ISSUE);
    assign bus.mem_mode  = mode_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.owner     = owner_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared cache/RAM memory block.
- Accepts independent read/write requests from port 0 and port 1 and serialises them onto one memory command interface with a valid/ready handshake.
- Returns read data or an error to the winning requester.
- Round-robin fairness; bounded wait via a timeout counter.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- TIMEOUT, 255, max cycles in ISSUE waiting for mem_ready before erroring; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- r0_req / r1_req  input  1  request from port 0 / port 1; held high with payload stable until that port's ack.
- r0_mode / r1_mode  input  1  1 = write, 0 = read.
- r0_addr / r1_addr  input  ADDR_W  word address.
- r0_wdata / r1_wdata  input  DATA_W  write data, ignored for reads.
- r0_ack / r1_ack  output  1  one-cycle completion pulse.
- r0_rdata / r1_rdata  output  DATA_W  read data, valid while that port's ack is high; 0 for writes and errors.
- r0_err / r1_err  output  1  timeout flag, valid with ack.
- mem_valid  output  1  command valid to the memory block.
- mem_mode  output  1  registered mode of the granted request.
- mem_addr  output  ADDR_W  registered address of the granted request.
- mem_wdata  output  DATA_W  registered write data of the granted request.
- mem_ready  input  1  memory accepts and completes the command in this cycle.
- mem_rdata  input  DATA_W  read data, valid in the cycle mem_valid && mem_ready.
- busy  output  1  high in ISSUE and RESP.
- owner  output  1  port currently granted; holds the last grant when idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_valid, busy, acks, errs, rdata, mem_* payload, owner.
  - last_owner = 1, so port 0 wins the first tie.
  - Timeout counter = 0.
- Reset mid-transaction: mem_valid drops immediately; the transaction is abandoned with no ack or err. After release the block starts in IDLE.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both reqs: grant the port != last_owner.
  - On grant: latch mode/addr/wdata into the mem_* registers, set owner and last_owner, clear the counter, go to ISSUE.
- ISSUE:
  - mem_valid = 1; mem_* payload held constant.
  - Transfer completes at the rising edge where mem_valid && mem_ready.
  - On completion: capture mem_rdata (reads) or 0 (writes) into the owner's rdata, err = 0, go to RESP.
  - Otherwise the counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without ready: next edge drops mem_valid, sets owner's rdata = 0 and err = 1, goes to RESP.
  - mem_ready in the same cycle as timeout expiry takes priority: normal completion.
- RESP:
  - Owner's ack = 1 for exactly one cycle.
  - The non-owner's ack, err and rdata stay 0.
  - Next state is always IDLE; reqs are not sampled in RESP.
  - Requester drops req on the edge where it samples ack. A req still high in the following IDLE is a new request.
- Latency: req high before edge E0 -> mem_valid high after E0. mem_ready high in that cycle -> ack high after E1 (2-edge minimum). Back-to-back throughput is one transaction per 3 cycles.
- mem_ready while not in ISSUE is ignored.
- Requester payload changing while req is high and not yet granted has no effect until grant. Payload change after grant is ignored (latched).
- rdata/err outputs hold their value only in the ack cycle; they return to 0 in IDLE.
- Counter width: ceil(log2(TIMEOUT+1)); no wrap, since it saturates into the state change.

Test Plan:
- Single read: r0_req, mode=0, addr=0x10; mem_ready=1 in first ISSUE cycle with mem_rdata=0xDEADBEEF -> mem_valid one cycle, mem_addr=0x10; r0_ack after 2 edges with r0_rdata=0xDEADBEEF, r0_err=0; r1_ack=0.
- Write with wait states: r1_req, mode=1, addr=0x3F, wdata=0x12345678; mem_ready delayed 4 cycles -> mem_valid high 5 cycles with stable payload; r1_ack pulse with r1_rdata=0, r1_err=0.
- Contention fairness: both reqs held continuously out of reset, 4 transactions, immediate ready -> grant order 0,1,0,1; each ack exactly one cycle; owner toggles.
- Timeout: TIMEOUT=8, r0 read, mem_ready held 0 -> mem_valid high exactly 8 cycles then low; r0_ack=1, r0_err=1, r0_rdata=0; next request proceeds normally.
- Ready at expiry: TIMEOUT=8, mem_ready=1 in the 8th ISSUE cycle with mem_rdata=0xA5A5A5A5 -> err=0, rdata=0xA5A5A5A5.
- Reset mid-ISSUE: assert rst_n=0 asynchronously during wait -> mem_valid, busy, owner drop immediately without a clock; no ack. After release, r0 and r1 both pending -> r0 granted first.
